// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and sizing helpers for the switch debouncer
package debounce_pkg;

   localparam int DEFAULT_CLK_HZ      = 50_000_000;
   localparam int DEFAULT_DEBOUNCE_MS = 10;

   // Cycles a new level must persist; never below one so the compare stays meaningful.
   function automatic int db_cycles(input int clk_hz, input int ms);
      int c;
      c = (clk_hz / 1000) * ms;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced switch bit; DEBOUNCE_SYNC_EN adds a 2-flop input synchroniser
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DB_CYCLES = 1,
   parameter int CNT_W     = cnt_width(DB_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic stable,
   output logic changed
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s;
   logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], sw};
      end
   end

   assign s = sync[1];
`else
   assign s = sw;
`endif

   // Counter only runs while the sample disagrees with the accepted level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         stable  <= 1'b0;
         changed <= 1'b0;
      end else if (s == stable) begin
         cnt     <= '0;
         changed <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         cnt     <= '0;
         stable  <= s;
         changed <= 1'b1;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         changed <= 1'b0;
      end
   end

endmodule

// File: rtl/debounce.sv
// rtl/debounce.sv - multi-channel switch debouncer; DEBOUNCE_SYNC_EN enables per-bit input synchronisers
module debounce
   import debounce_pkg::*;
#(
   parameter int CLK_HZ      = DEFAULT_CLK_HZ,
   parameter int DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
   parameter int NUM_SW      = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_SW-1:0] switches,
   output logic [NUM_SW-1:0] switches_stable,
   output logic [NUM_SW-1:0] switch_changed
);

   localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int CNT_W     = cnt_width(DB_CYCLES);

   for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      debounce_channel #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .sw      (switches[i]),
         .stable  (switches_stable[i]),
         .changed (switch_changed[i])
      );
   end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - scoreboard bench for debounce with random and directed switch activity
module tb_debounce;

   localparam int NSW = 18;
   localparam int DB  = 1000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NSW-1:0] switches = '0;
   logic [NSW-1:0] stable, changed, stable1, changed1;

   always #5 clk = ~clk;

   debounce #(.CLK_HZ(1_000_000), .DEBOUNCE_MS(1), .NUM_SW(NSW)) dut (
      .clk(clk), .rst_n(rst_n), .switches(switches),
      .switches_stable(stable), .switch_changed(changed));

   // CLK_HZ/1000 rounds to zero here, so this instance runs with a one-cycle window.
   debounce #(.CLK_HZ(500), .DEBOUNCE_MS(1), .NUM_SW(NSW)) dut1 (
      .clk(clk), .rst_n(rst_n), .switches(switches),
      .switches_stable(stable1), .switch_changed(changed1));

   typedef struct {
      int             edge_n;
      logic [NSW-1:0] mask;
      logic [NSW-1:0] st;
   } ev_t;

   ev_t            exp_q[$];
   ev_t            mon_e;
   int             errors = 0;
   int             checks = 0;
   int             edge_n = 0;
   bit             started = 0;
   logic [NSW-1:0] exp_stable = '0;
   logic [NSW-1:0] exp_st1 = '0;
   logic [NSW-1:0] exp_ch1 = '0;
   logic [NSW-1:0] h0 = '0, h1 = '0;
   int             last_agree[NSW];
   int             pulses[NSW];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
      end
   endtask

   // A level is accepted once it has disagreed with the accepted level on DB consecutive edges.
   task automatic model_edge(input logic [NSW-1:0] sw, input logic rn);
      logic [NSW-1:0] s, mask;
      ev_t e;
      edge_n++;
`ifdef DEBOUNCE_SYNC_EN
      s = h1;
`else
      s = sw;
`endif
      if (!rn) begin
         h0 = '0; h1 = '0;
         exp_stable = '0; exp_st1 = '0; exp_ch1 = '0;
         for (int i = 0; i < NSW; i++) last_agree[i] = edge_n;
         return;
      end
      h1 = h0; h0 = sw;
      mask = '0;
      for (int i = 0; i < NSW; i++) begin
         if (s[i] == exp_stable[i]) last_agree[i] = edge_n;
         else if (edge_n - last_agree[i] == DB) begin
            mask[i] = 1'b1;
            last_agree[i] = edge_n;
         end
      end
      exp_stable = exp_stable ^ mask;
      if (mask != '0) begin
         e.edge_n = edge_n; e.mask = mask; e.st = exp_stable;
         exp_q.push_back(e);
      end
      exp_ch1 = s ^ exp_st1;
      exp_st1 = s;
   endtask

   task automatic tick(input logic [NSW-1:0] sw, input logic rn);
      switches = sw;
      rst_n = rn;
      @(posedge clk);
      model_edge(sw, rn);
      #1;
   endtask

   task automatic hold(input logic [NSW-1:0] sw, input int n);
      for (int k = 0; k < n; k++) tick(sw, 1'b1);
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("stable", 32'(stable), 32'(exp_stable));
         check("db1_stable", 32'(stable1), 32'(exp_st1));
         check("db1_changed", 32'(changed1), 32'(exp_ch1));
         if (changed != '0) begin
            for (int i = 0; i < NSW; i++) if (changed[i]) pulses[i]++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL pulse_unexpected: got %0h expected none (edge %0d)", changed, edge_n);
            end else begin
               mon_e = exp_q.pop_front();
               check("pulse_mask", 32'(changed), 32'(mon_e.mask));
               check("pulse_edge", 32'(edge_n), 32'(mon_e.edge_n));
               check("pulse_stable", 32'(stable), 32'(mon_e.st));
            end
         end else if (exp_q.size() != 0 && exp_q[0].edge_n < edge_n) begin
            mon_e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL pulse_missing: got 0 expected %0h (edge %0d)", mon_e.mask, mon_e.edge_n);
         end
      end
   end

   initial begin
      logic [NSW-1:0] cur;
      int             p5;

      // 1: reset with all switches high, then acceptance of every channel
      tick(18'h3FFFF, 1'b0);
      started = 1;
      for (int k = 0; k < 4; k++) tick(18'h3FFFF, 1'b0);
      hold(18'h3FFFF, 1010);
      for (int i = 0; i < NSW; i++) check("t1_pulse_count", 32'(pulses[i]), 32'd1);
      check("t1_stable", 32'(stable), 32'h3FFFF);
      hold('0, 1010);
      check("t1_released", 32'(stable), 32'h0);

      // 2: press with bounce on sw[0]
      cur = '0;
      hold(cur | 18'h1, 3); hold(cur, 3);
      hold(cur | 18'h1, 500);
      check("t2_mid", 32'(stable[0]), 32'd0);
      hold(cur | 18'h1, 510);
      check("t2_accepted", 32'(stable[0]), 32'd1);

      // 3: release with bounce on sw[0]
      hold(cur, 3); hold(cur | 18'h1, 3);
      hold(cur, 1010);
      check("t3_released", 32'(stable[0]), 32'd0);

      // 4: 999-cycle glitch on sw[5] is rejected
      p5 = pulses[5];
      hold(18'h20, 999);
      hold('0, 20);
      check("t4_no_pulse", 32'(pulses[5]), 32'(p5));
      check("t4_stable", 32'(stable[5]), 32'd0);

      // 5: independent channels 10 cycles apart
      hold(18'h1, 10);
      hold(18'h21, 1020);
      check("t5_stable", 32'(stable), 32'h21);

      // 6: reset partway through sw[3]'s count
      hold(18'h29, 600);
      tick(18'h29, 1'b0);
      check("t6_reset_clear", 32'(stable), 32'h0);
      hold(18'h29, 1010);
      check("t6_stable", 32'(stable), 32'h29);

      // random activity: some runs long enough to be accepted, most bouncing
      cur = 18'h29;
      for (int k = 0; k < 15000; k++) begin
         for (int i = 0; i < NSW; i++)
            if ($urandom_range(599) == 0) cur[i] = ~cur[i];
         tick(cur, 1'b1);
      end
      hold(cur, 1010);
      check("final_stable", 32'(stable), 32'(cur));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
